// File: rtl/shifter_pkg.sv
// Shared types and constants for the serial shifter: FSM state encoding and direction codes.
package shifter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam logic SFT_LEFT  = 1'b1;
    localparam logic SFT_RIGHT = 1'b0;

endpackage

// File: rtl/shift_step_1b.sv
// Single-bit shift/rotate step used once per SHIFT cycle by shifter_serial.
module shift_step_1b
    import shifter_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] data,
    input  logic             dir,
    input  logic             rot,
    output logic [WIDTH-1:0] data_c
);

    logic fill_l;
    logic fill_r;

    // Rotation re-injects the bit falling off the far end; otherwise zero-fill.
    always_comb begin
        fill_l = rot & data[WIDTH-1];
        fill_r = rot & data[0];
        if (dir == SFT_LEFT) begin
            data_c = {data[WIDTH-2:0], fill_l};
        end else begin
            data_c = {fill_r, data[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/shifter_serial.sv
// Bit-serial shifter: one bit position per cycle, valid/ready on both sides.
// Optional macro SHIFTER_SERIAL_ROTATE_EN adds a 'rotate' input for rotate instead of zero-fill.
module shifter_serial
    import shifter_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             left_right,
    input  logic [SHW-1:0]   shamt,
    input  logic [WIDTH-1:0] sft_src,
`ifdef SHIFTER_SERIAL_ROTATE_EN
    input  logic             rotate,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             rot_q, rot_d;
    logic             rot_in;
    logic [WIDTH-1:0] step_c;

`ifdef SHIFTER_SERIAL_ROTATE_EN
    assign rot_in = rotate;
`else
    assign rot_in = 1'b0;
`endif

    shift_step_1b #(.WIDTH(WIDTH)) u_step (
        .data   (data_q),
        .dir    (dir_q),
        .rot    (rot_q),
        .data_c (step_c)
    );

    // Next-state and datapath update; operands are only sampled on an accept.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        rot_d   = rot_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    data_d  = sft_src;
                    cnt_d   = shamt;
                    dir_d   = left_right;
                    rot_d   = rot_in;
                    state_d = (shamt != '0) ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                data_d = step_c;
                cnt_d  = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            dir_q   <= SFT_RIGHT;
            rot_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            rot_q   <= rot_d;
        end
    end

    // Handshake/status outputs are registered copies of the next state; result is masked outside DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            result    <= '0;
        end else begin
            in_ready  <= (state_d == ST_IDLE);
            out_valid <= (state_d == ST_DONE);
            busy      <= (state_d != ST_IDLE);
            result    <= (state_d == ST_DONE) ? data_d : '0;
        end
    end

endmodule
